// File: rtl/seq_divider_8b4b_if.sv
// ---------------------------------------------------------------------------
// seq_divider_8b4b_if
//
// Purpose : groups the request/result signals of the sequential 8b/4b
//           divider so the design and its environment share one bundle.
//
// Signals :
//   start     request; sampled on a rising clk edge when the divider is idle
//   A  [7:0]  dividend, captured when start is accepted
//   B  [3:0]  divisor, captured when start is accepted
//   busy      high while an operation is in progress
//   done      one-cycle pulse; Q, R and dbz are valid while it is high
//   Q  [7:0]  quotient, held until the next completion
//   R  [3:0]  remainder, held until the next completion
//   dbz       divide-by-zero flag of the last result, held with Q/R
//   state_dbg current FSM state (0=IDLE, 1=CALC, 2=DONE) for observation
//
// Handshake: the requester raises start with A/B valid; the divider takes
// them on the first rising edge where it is not busy (IDLE or DONE).  While
// busy is high start is ignored and A/B may change freely.  Exactly
// one done pulse follows every accepted start unless rstn aborts it.
//
// Modports:
//   master : requester side (drives start/A/B, observes results)
//   slave  : divider side   (observes start/A/B, drives results)
// ---------------------------------------------------------------------------
interface seq_divider_8b4b_if;
    logic       start;
    logic [7:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [3:0] R;
    logic       dbz;
    logic [1:0] state_dbg;

    modport master (
        output start,
        output A,
        output B,
        input  busy,
        input  done,
        input  Q,
        input  R,
        input  dbz,
        input  state_dbg
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output busy,
        output done,
        output Q,
        output R,
        output dbz,
        output state_dbg
    );
endinterface

// File: rtl/seq_divider_8b4b.sv
// ---------------------------------------------------------------------------
// seq_divider_8b4b
//
// Purpose : sequential restoring divider, 8-bit unsigned dividend by 4-bit
//           unsigned divisor, producing an 8-bit quotient and a 4-bit
//           remainder.  One quotient bit is produced per clock, so a
//           division takes 8 cycles from the accepting edge to the result
//           latch, followed by a one-cycle done pulse.
//
// Ports   :
//   clk   rising-edge clock
//   rstn  asynchronous, active-low reset
//   bus   seq_divider_8b4b_if.slave (start/A/B in, busy/done/Q/R/dbz and
//         state_dbg out)
//
// Build option:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor finishes after a single
//                     CALC cycle (results latched at the edge after the
//                     accepting edge).  When undefined, a zero divisor runs
//                     the full 8 iterations, which naturally yields
//                     Q=8'hFF, R=A[3:0].  Results for B!=0 are the same in
//                     both builds.
// ---------------------------------------------------------------------------
module seq_divider_8b4b (
    input  logic                  clk,
    input  logic                  rstn,
    seq_divider_8b4b_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t     state_q,    state_d;
    logic [7:0] dividend_q, dividend_d;   // shifts left, MSB feeds the remainder
    logic [3:0] divisor_q,  divisor_d;
    // The partial remainder is restored to a value below the divisor after
    // every step, so only 4 bits need storing; the fifth bit exists only in
    // the shifted trial value below.
    logic [3:0] rem_q,      rem_d;
    // Seven accumulated quotient bits; the eighth is appended combinationally
    // on the final iteration when the result is latched.
    logic [6:0] quot_q,     quot_d;
    logic [2:0] cnt_q,      cnt_d;        // iteration index 0..7
    logic [7:0] q_res_q,    q_res_d;
    logic [3:0] r_res_q,    r_res_d;
    logic       dbz_q,      dbz_d;

    // -----------------------------------------------------------------------
    // One restoring-division step, evaluated every cycle and used only in CALC
    // -----------------------------------------------------------------------
    logic [4:0] rem_shift;   // {partial remainder, next dividend bit}
    logic [3:0] rem_sub;     // trial difference, valid when q_bit is set
    logic       q_bit;       // quotient bit produced by this step
    logic [3:0] rem_step;    // partial remainder after restore/subtract

    always_comb begin
        rem_shift = {rem_q, dividend_q[7]};
        q_bit     = (rem_shift >= {1'b0, divisor_q});
        // When q_bit is set the true difference is below 16, so the 4-bit
        // wrap-around subtraction gives the exact result.
        rem_sub   = rem_shift[3:0] - divisor_q;
        rem_step  = q_bit ? rem_sub : rem_shift[3:0];
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        q_res_d    = q_res_q;
        r_res_d    = r_res_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // Accept a new operation; from DONE this gives
                    // back-to-back divisions with no idle cycle.
                    dividend_d = bus.A;
                    divisor_d  = bus.B;
                    rem_d      = 4'h0;
                    quot_d     = 7'h00;
                    cnt_d      = 3'd0;
                    state_d    = S_CALC;
                end else begin
                    state_d    = S_IDLE;
                end
            end

            S_CALC: begin
`ifdef DIV_ZERO_FAST_EN
                if (divisor_q == 4'h0) begin
                    // The dividend has not shifted yet in the first CALC
                    // cycle, so its low nibble is the original A[3:0].
                    q_res_d = 8'hFF;
                    r_res_d = dividend_q[3:0];
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dividend_d = {dividend_q[6:0], 1'b0};
                    rem_d      = rem_step;
                    quot_d     = {quot_q[5:0], q_bit};
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        q_res_d = {quot_q, q_bit};
                        r_res_d = rem_step;
                        dbz_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
`else
                dividend_d = {dividend_q[6:0], 1'b0};
                rem_d      = rem_step;
                quot_d     = {quot_q[5:0], q_bit};
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    // A zero divisor makes every step subtract zero, which
                    // yields all-ones quotient and A[3:0] as the remainder.
                    q_res_d = {quot_q, q_bit};
                    r_res_d = rem_step;
                    dbz_d   = (divisor_q == 4'h0);
                    state_d = S_DONE;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            dividend_q <= 8'h00;
            divisor_q  <= 4'h0;
            rem_q      <= 4'h0;
            quot_q     <= 7'h00;
            cnt_q      <= 3'd0;
            q_res_q    <= 8'h00;
            r_res_q    <= 4'h0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            q_res_q    <= q_res_d;
            r_res_q    <= r_res_d;
            dbz_q      <= dbz_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: busy and done decode directly from the state, so they can
    // never be high together and both drop immediately on reset.
    // -----------------------------------------------------------------------
    assign bus.busy      = (state_q == S_CALC);
    assign bus.done      = (state_q == S_DONE);
    assign bus.Q         = q_res_q;
    assign bus.R         = r_res_q;
    assign bus.dbz       = dbz_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seq_divider_8b4b.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_8b4b : self-checking bench for seq_divider_8b4b.
// Vector table from the worked examples, hand-written sequences for the
// multi-cycle corners (ignored start, back-to-back, mid-CALC reset),
// randomized operations against a plain arithmetic model, and an exhaustive
// sweep of all non-zero divisors checking A == Q*B + R and R < B.
// ---------------------------------------------------------------------------
module tb_seq_divider_8b4b;

    logic clk;
    logic rstn;

    seq_divider_8b4b_if bus ();

    seq_divider_8b4b dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if (bus.busy && bus.done) begin
                failures++;
                $display("FAIL busy_done_excl: actual=1 required=0");
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return 8'hFF;
        return 8'(int'(a) / int'(b));
    endfunction

    function automatic logic [3:0] ref_r(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return a[3:0];
        return 4'(int'(a) % int'(b));
    endfunction

    function automatic int ref_lat(input logic [3:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 4'd0) return 1;
`endif
        return 8;
    endfunction

    // ---------------- driver ----------------
    // Starts one operation and waits for done. lat counts edges after the
    // accepting edge until done is seen; busy_cyc counts busy cycles.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          output logic [7:0] q, output logic [3:0] r,
                          output logic z, output int lat, output int busy_cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 8'($urandom_range(255));
        bus.B     = 4'($urandom_range(15));
        lat       = 0;
        busy_cyc  = 0;
        while (!bus.done && lat < 30) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        q = bus.Q;
        r = bus.R;
        z = bus.dbz;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        int         bcyc;
        int         cnt;
        int         done_seen;
        logic [7:0] ra;
        logic [3:0] rb;

        checks   = 0;
        failures = 0;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
        vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
        vecs[3] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0};
        vecs[4] = '{8'd37,  4'd0,  8'hFF,  4'd5, 1'b1};
        vecs[5] = '{8'd17,  4'd4,  8'd4,   4'd1, 1'b0};

        // ---------------- reset ----------------
        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.A     = 8'd0;
        bus.B     = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_q",    32'(bus.Q),    0);
        check("rst_r",    32'(bus.R),    0);
        check("rst_dbz",  32'(bus.dbz),  0);
        rstn = 1'b1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, r, z, lat, bcyc);
            check("vec_q",    32'(q),    32'(vecs[i].q));
            check("vec_r",    32'(r),    32'(vecs[i].r));
            check("vec_dbz",  32'(z),    32'(vecs[i].z));
            check("vec_lat",  32'(lat),  32'(ref_lat(vecs[i].b)));
            check("vec_busy", 32'(bcyc), 32'(ref_lat(vecs[i].b)));
        end

        // ---------------- start ignored during CALC ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.A = 8'd200; bus.B = 4'd7;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 30) begin
            if (lat == 3) begin
                bus.start = 1'b1; bus.A = 8'd9; bus.B = 4'd2;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("ign_lat", 32'(lat),   8);
        check("ign_q",   32'(bus.Q), 28);
        check("ign_r",   32'(bus.R), 4);

        // ---------------- back-to-back ----------------
        // still in the done cycle of the previous op: hold start high now
        bus.start = 1'b1; bus.A = 8'd100; bus.B = 4'd10;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 1;
        check("b2b_busy", 32'(bus.busy), 1);
        check("b2b_hold_q", 32'(bus.Q), 28);
        check("b2b_hold_r", 32'(bus.R), 4);
        while (!bus.done && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_gap", 32'(cnt),   9);
        check("b2b_q",   32'(bus.Q), 10);
        check("b2b_r",   32'(bus.R), 0);

        // ---------------- reset mid-CALC ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.A = 8'd200; bus.B = 4'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_calc", 32'(bus.busy), 1);
        rstn = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_q",    32'(bus.Q),    0);
        check("abort_r",    32'(bus.R),    0);
        check("abort_dbz",  32'(bus.dbz),  0);
        @(negedge clk);
        rstn = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 0);
        run_op(8'd17, 4'd4, q, r, z, lat, bcyc);
        check("post_rst_q",   32'(q),   4);
        check("post_rst_r",   32'(r),   1);
        check("post_rst_lat", 32'(lat), 8);

        // ---------------- randomized vs model ----------------
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(255));
            rb = (i % 10 == 0) ? 4'd0 : 4'($urandom_range(15));
            run_op(ra, rb, q, r, z, lat, bcyc);
            check("rnd_q",   32'(q),   32'(ref_q(ra, rb)));
            check("rnd_r",   32'(r),   32'(ref_r(ra, rb)));
            check("rnd_dbz", 32'(z),   32'(rb == 4'd0));
            check("rnd_lat", 32'(lat), 32'(ref_lat(rb)));
        end

        // ---------------- exhaustive invariant sweep ----------------
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a), 4'(b), q, r, z, lat, bcyc);
                check("inv_sum", 32'(int'(q) * b + int'(r)), 32'(a));
                check("inv_rlt", 32'(int'(r) < b), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
